// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 single-port memory arbiter.
// Round-robin arbitration is enabled by defining LC3_MEM_ARB_RR_EN.
package lc3_mem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam int CW     = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } arb_state_t;

    typedef enum logic {
        OWN_F,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic              we;
        logic [DW_DEF-1:0] wdata;
    } mem_req_t;

    function automatic owner_t other_owner(owner_t o);
        return (o == OWN_F) ? OWN_D : OWN_F;
    endfunction

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Request/response and memory-side signals of the LC-3 memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface lc3_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          f_valid;
    logic [AW-1:0] f_addr;
    logic          f_ready;
    logic          f_rsp_valid;
    logic [DW-1:0] f_rsp_data;

    logic          d_valid;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  f_valid, f_addr,
        output f_ready, f_rsp_valid, f_rsp_data,
        input  d_valid, d_we, d_addr, d_wdata,
        output d_ready, d_rsp_valid, d_rsp_data,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output f_valid, f_addr,
        input  f_ready, f_rsp_valid, f_rsp_data,
        output d_valid, d_we, d_addr, d_wdata,
        input  d_ready, d_rsp_valid, d_rsp_data,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/lc3_mem_arb_pick.sv
// Combinational winner selection between fetch (F) and data (D) ports.
// LC3_MEM_ARB_RR_EN selects round-robin tie breaking instead of D-first.
module lc3_mem_arb_pick
    import lc3_mem_pkg::*;
(
    input  logic   f_valid,
    input  logic   d_valid,
    output logic   grant,
    output owner_t win
`ifdef LC3_MEM_ARB_RR_EN
    ,
    input  owner_t last_owner
`endif
);

    owner_t tie_win;

`ifdef LC3_MEM_ARB_RR_EN
    // the port that lost the previous grant wins a tie
    assign tie_win = other_owner(last_owner);
`else
    assign tie_win = OWN_D;
`endif

    assign grant = f_valid | d_valid;

    always_comb begin
        win = OWN_F;
        unique case (1'b1)
            (f_valid && d_valid): win = tie_win;
            (d_valid && !f_valid): win = OWN_D;
            default: win = OWN_F;
        endcase
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the LC-3 single-port memory between instruction fetch and data.
// Define LC3_MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF
) (
    input logic               clk,
    input logic               reset,
    lc3_mem_arbiter_if.slave  bus
);

    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mem_req_t      req_q, req_d;
    owner_t        owner_q, owner_d;

    logic          f_rv_q, f_rv_d;
    logic          d_rv_q, d_rv_d;
    logic [DW-1:0] f_rd_q, f_rd_d;
    logic [DW-1:0] d_rd_q, d_rd_d;

    logic          f_rdy;
    logic          d_rdy;
    logic [AW-1:0] sel_addr;
    logic          last;
    logic          grant;
    owner_t        win;

`ifdef LC3_MEM_ARB_RR_EN
    owner_t        last_q, last_d;
`endif

    lc3_mem_arb_pick u_pick (
        .f_valid    (bus.f_valid),
        .d_valid    (bus.d_valid),
        .grant      (grant),
        .win        (win)
`ifdef LC3_MEM_ARB_RR_EN
        ,
        .last_owner (last_q)
`endif
    );

    assign last = (cnt_q == WAIT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        owner_d  = owner_q;
        f_rv_d   = 1'b0;
        d_rv_d   = 1'b0;
        f_rd_d   = f_rd_q;
        d_rd_d   = d_rd_q;
        f_rdy    = 1'b0;
        d_rdy    = 1'b0;
        sel_addr = bus.f_addr;
`ifdef LC3_MEM_ARB_RR_EN
        last_d   = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    f_rdy       = (win == OWN_F);
                    d_rdy       = (win == OWN_D);
                    sel_addr    = d_rdy ? bus.d_addr : bus.f_addr;
                    req_d.addr  = sel_addr;
                    // fetch is always a read
                    req_d.we    = d_rdy & bus.d_we;
                    req_d.wdata = d_rdy ? bus.d_wdata : '0;
                    owner_d     = win;
                    cnt_d       = '0;
                    state_d     = ACCESS;
`ifdef LC3_MEM_ARB_RR_EN
                    last_d      = win;
`endif
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (owner_q == OWN_D) begin
                        d_rv_d = 1'b1;
                        d_rd_d = req_q.we ? '0 : bus.mem_rdata;
                    end else begin
                        f_rv_d = 1'b1;
                        f_rd_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            owner_q <= OWN_F;
            f_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
            f_rd_q  <= '0;
            d_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            f_rv_q  <= f_rv_d;
            d_rv_q  <= d_rv_d;
            f_rd_q  <= f_rd_d;
            d_rd_q  <= d_rd_d;
        end
    end

`ifdef LC3_MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_F;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.f_ready     = f_rdy;
    assign bus.d_ready     = d_rdy;
    assign bus.f_rsp_valid = f_rv_q;
    assign bus.d_rsp_valid = d_rv_q;
    assign bus.f_rsp_data  = f_rd_q;
    assign bus.d_rsp_data  = d_rd_q;
    assign bus.mem_addr    = req_q.addr;
    assign bus.mem_wdata   = req_q.wdata;
    // decoded from state so a reset mid-access kills the write at once
    assign bus.mem_we      = (state_q == ACCESS) && last && req_q.we;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed and random traffic against a
// transaction-level model (latency, arbitration rule, shadow memory).
module tb_lc3_mem_arbiter;

    localparam int W = 2;

    typedef struct {
        int          cyc;
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    lc3_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    lc3_mem_arbiter #(
        .WAIT_CYCLES (W),
        .AW          (16),
        .DW          (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] tb_mem [0:65535];
    logic [15:0] shadow [0:65535];

    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int next_free = 0;
    int acc_start = 0;
    int acc_end = -1;
    logic [15:0] acc_addr = '0;
    logic [15:0] acc_wdata = '0;
    bit acc_we = 1'b0;
    bit last_d = 1'b0;
    exp_t exp_q[$];

    bit f_pend = 1'b0;
    logic [15:0] f_addr_r = '0;
    bit d_pend = 1'b0;
    bit d_we_r = 1'b0;
    logic [15:0] d_addr_r = '0;
    logic [15:0] d_wdata_r = '0;
    int f_rate = 0;
    int d_rate = 0;
    int obs_gd = 0;
    int obs_gf = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %h, expected %h (cycle %0d)",
                         tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int k = $urandom_range(0, 9);
        if (k == 0) return 16'hFFFF;
        if (k == 1) return 16'h0000;
        if (k < 7) return 16'h0100 + 16'($urandom_range(0, 15));
        return 16'($urandom);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        f_pend = 1'b0;
        d_pend = 1'b0;
        acc_addr = '0;
        acc_wdata = '0;
        acc_we = 1'b0;
        acc_start = 0;
        acc_end = -1;
        last_d = 1'b0;
    endtask

    // one clock: drive at posedge+1, check at negedge
    task automatic run_cycle();
        exp_t e;
        bit idle, win_d, exp_fr, exp_dr, fv, dv;
        if (!f_pend && $urandom_range(0, 99) < f_rate) begin
            f_pend = 1'b1;
            f_addr_r = rand_addr();
        end
        if (!d_pend && $urandom_range(0, 99) < d_rate) begin
            d_pend = 1'b1;
            d_we_r = 1'($urandom_range(0, 1));
            d_addr_r = rand_addr();
            d_wdata_r = 16'($urandom);
        end
        bus.f_valid = f_pend;
        bus.f_addr  = f_pend ? f_addr_r : 16'($urandom);
        bus.d_valid = d_pend;
        bus.d_we    = d_pend ? d_we_r : 1'($urandom);
        bus.d_addr  = d_pend ? d_addr_r : 16'($urandom);
        bus.d_wdata = d_pend ? d_wdata_r : 16'($urandom);
        @(negedge clk);
        check("mem_we", bus.mem_we, (cyc == acc_end) && acc_we);
        check("mem_addr", bus.mem_addr, acc_addr);
        if (acc_we && cyc >= acc_start && cyc <= acc_end)
            check("mem_wdata", bus.mem_wdata, acc_wdata);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        fv = exp_q.size() > 0 && exp_q[0].cyc == cyc && !exp_q[0].is_d;
        dv = exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].is_d;
        check("f_rsp_valid", bus.f_rsp_valid, fv);
        check("d_rsp_valid", bus.d_rsp_valid, dv);
        if (fv || dv) begin
            e = exp_q.pop_front();
            if (fv) check("f_rsp_data", bus.f_rsp_data, e.data);
            else check("d_rsp_data", bus.d_rsp_data, e.data);
            if (e.we) shadow[e.addr] = e.wdata;
        end
        idle = (cyc >= next_free);
`ifdef LC3_MEM_ARB_RR_EN
        win_d = d_pend && (!f_pend || !last_d);
`else
        win_d = d_pend;
`endif
        exp_dr = idle && win_d;
        exp_fr = idle && f_pend && !win_d;
        check("f_ready", bus.f_ready, exp_fr);
        check("d_ready", bus.d_ready, exp_dr);
        if (bus.d_ready) obs_gd++;
        if (bus.f_ready) obs_gf++;
        if (exp_fr || exp_dr) begin
            e.cyc   = cyc + 2 + W;
            e.is_d  = exp_dr;
            e.we    = exp_dr && d_we_r;
            e.addr  = exp_dr ? d_addr_r : f_addr_r;
            e.wdata = d_wdata_r;
            e.data  = e.we ? 16'h0000 : shadow[e.addr];
            exp_q.push_back(e);
            acc_start = cyc + 1;
            acc_end   = cyc + 1 + W;
            acc_addr  = e.addr;
            acc_we    = e.we;
            acc_wdata = d_wdata_r;
            next_free = cyc + 2 + W;
            last_d    = exp_dr;
            if (exp_dr) d_pend = 1'b0;
            else f_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic d_req(input bit we, input logic [15:0] a,
                         input logic [15:0] wd);
        d_pend = 1'b1;
        d_we_r = we;
        d_addr_r = a;
        d_wdata_r = wd;
        run_n(2 * (W + 2) + 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i] = '0;
            shadow[i] = '0;
        end
        bus.f_valid = 1'b0;
        bus.f_addr = '0;
        bus.d_valid = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_f_ready", bus.f_ready, 0);
        check("rst_d_ready", bus.d_ready, 0);
        check("rst_f_rsp_valid", bus.f_rsp_valid, 0);
        check("rst_d_rsp_valid", bus.d_rsp_valid, 0);
        check("rst_f_rsp_data", bus.f_rsp_data, 0);
        check("rst_d_rsp_data", bus.d_rsp_data, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_we", bus.mem_we, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        next_free = 0;

        tb_mem[16'h3000] = 16'h1234;
        shadow[16'h3000] = 16'h1234;
        f_pend = 1'b1;
        f_addr_r = 16'h3000;
        run_n(2 * (W + 2));

        d_req(1'b1, 16'h00FF, 16'hBEEF);
        d_req(1'b0, 16'h00FF, 16'h0000);
        d_req(1'b1, 16'hFFFF, 16'hA5A5);
        d_req(1'b1, 16'h0000, 16'h5A5A);
        f_pend = 1'b1;
        f_addr_r = 16'hFFFF;
        run_n(2 * (W + 2));
        d_req(1'b0, 16'h0000, 16'h0000);

        obs_gd = 0;
        obs_gf = 0;
        f_rate = 100;
        d_rate = 100;
        for (int i = 0; i < 200 && (obs_gd + obs_gf) < 8; i++) run_cycle();
`ifdef LC3_MEM_ARB_RR_EN
        check("tie_grants_d", obs_gd, 4);
        check("tie_grants_f", obs_gf, 4);
`else
        check("tie_grants_d", obs_gd, 8);
        check("tie_grants_f", obs_gf, 0);
`endif
        f_rate = 0;
        d_rate = 0;
        run_n(4 * (W + 2));

        f_rate = 40;
        d_rate = 40;
        run_n(3000);
        f_rate = 0;
        d_rate = 0;
        run_n(4 * (W + 2));

        tb_mem[16'h0010] = 16'h5555;
        shadow[16'h0010] = 16'h5555;
        d_pend = 1'b1;
        d_we_r = 1'b1;
        d_addr_r = 16'h0010;
        d_wdata_r = 16'hDEAD;
        run_n(1 + W);
        check("we_before_rst", bus.mem_we, 1);
        reset = 1'b0;
        #1;
        check("rst_mid_mem_we", bus.mem_we, 0);
        check("rst_mid_mem_addr", bus.mem_addr, 0);
        check("rst_mid_mem_wdata", bus.mem_wdata, 0);
        check("rst_mid_d_ready", bus.d_ready, 0);
        check("rst_mid_f_rsp_data", bus.f_rsp_data, 0);
        check("rst_mid_d_rsp_data", bus.d_rsp_data, 0);
        bus.d_valid = 1'b0;
        bus.f_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_d_rsp_valid", bus.d_rsp_valid, 0);
        check("rst_mid_mem_kept", tb_mem[16'h0010], shadow[16'h0010]);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        next_free = cyc;
        d_req(1'b0, 16'h0010, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
